// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions.
//   DATA_W  : operand/result width
//   SHAMT_W : log2(DATA_W), number of barrel-shifter stages
//   word_t  : one datapath word
package alu_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;

   typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/right_shift_arithmetic_if.sv
// Operand/result bundle for the arithmetic right shifter.
//   A                        : operand, two's complement
//   B                        : shift amount, full-width unsigned
//   RightShiftedArithmetic_A : registered A >>> B
// master drives operands and reads the result; slave is the shifter side.
interface right_shift_arithmetic_if;
   import alu_pkg::*;

   word_t A;
   word_t B;
   word_t RightShiftedArithmetic_A;

   modport master (
      output A,
      output B,
      input  RightShiftedArithmetic_A
   );

   modport slave (
      input  A,
      input  B,
      output RightShiftedArithmetic_A
   );

endinterface

// File: rtl/sra_stage.sv
// One fixed-distance stage of the arithmetic barrel shifter.
//   W      : data width
//   K      : fixed shift distance of this stage
//   data   : input word
//   sign   : bit replicated into the vacated MSBs
//   enable : shift when set, pass through otherwise
//   result : enable ? {K sign bits, data[W-1:K]} : data
module sra_stage #(
   parameter int unsigned W = 32,
   parameter int unsigned K = 1
) (
   input  logic [W-1:0] data,
   input  logic         sign,
   input  logic         enable,
   output logic [W-1:0] result
);

   assign result = enable ? {{K{sign}}, data[W-1:K]} : data;

endmodule

// File: rtl/right_shift_arithmetic.sv
// Registered arithmetic right shifter (SRA/SRAV) for the ALU result mux.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset; clears the result register
//   bus : slave side of right_shift_arithmetic_if (A, B in; result out)
// One cycle of latency, a new operand pair every cycle, no handshake.
module right_shift_arithmetic
   import alu_pkg::*;
(
   input logic                     clk,
   input logic                     rst,
   right_shift_arithmetic_if.slave bus
);

   word_t stageData [SHAMT_W+1];
   logic  sign;
   logic  saturate;
   word_t resultD;
   word_t resultQ;

   assign sign         = bus.A[DATA_W-1];
   assign stageData[0] = bus.A;

   // Log-depth barrel: stage i shifts by 2**i when B[i] is set.
   for (genvar i = 0; i < SHAMT_W; i++) begin : gStage
      sra_stage #(
         .W (DATA_W),
         .K (2 ** i)
      ) uStage (
         .data   (stageData[i]),
         .sign   (sign),
         .enable (bus.B[i]),
         .result (stageData[i+1])
      );
   end

   // B is never truncated: any upper bit set means the amount is >= DATA_W,
   // which leaves only copies of the sign bit.
   assign saturate = |bus.B[DATA_W-1:SHAMT_W];

   always_comb begin
      resultD = stageData[SHAMT_W];
      if (saturate) begin
         resultD = {DATA_W{sign}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resultQ <= '0;
      end else begin
         resultQ <= resultD;
      end
   end

   assign bus.RightShiftedArithmetic_A = resultQ;

endmodule

// File: tb/tb_right_shift_arithmetic.sv
// Scoreboard bench for right_shift_arithmetic: the stimulus process drives one
// operand pair per cycle and queues the expected result; the monitor pops and
// compares one entry after every rising edge.
module tb_right_shift_arithmetic;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   right_shift_arithmetic_if bus ();

   right_shift_arithmetic dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   word_t expQ [$];
   string nameQ [$];
   word_t aQ [$];
   word_t bQ [$];
   int    nTests = 0;
   int    nFail  = 0;

   // Reference model: sign-fill for out-of-range amounts, else signed shift.
   function automatic word_t sraModel(input word_t a, input word_t b);
      word_t r;
      if (b >= 32'd32) begin
         r = {DATA_W{a[DATA_W-1]}};
      end else begin
         r = word_t'($signed(a) >>> b[4:0]);
      end
      return r;
   endfunction

   task automatic drive(input logic r, input word_t a, input word_t b, input word_t e,
                        input string n);
      @(negedge clk);
      rst   = r;
      bus.A = a;
      bus.B = b;
      expQ.push_back(e);
      nameQ.push_back(n);
      aQ.push_back(a);
      bQ.push_back(b);
   endtask

   // Monitor: every edge consumes exactly one queued expectation, so a result
   // arriving a cycle early or late misaligns against the queue.
   initial begin
      word_t e;
      word_t a;
      word_t b;
      string n;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            a = aQ.pop_front();
            b = bQ.pop_front();
            nTests++;
            if (bus.RightShiftedArithmetic_A !== e) begin
               nFail++;
               $display("FAIL %s: A=%h B=%h got %h expected %h", n, a, b,
                        bus.RightShiftedArithmetic_A, e);
            end
         end
      end
   end

   typedef struct {
      word_t a;
      word_t b;
      word_t e;
      string n;
   } vec_t;

   vec_t vecs [$];

   initial begin
      word_t a;
      word_t b;
      int    waitCnt;

      rst   = 1'b1;
      bus.A = '0;
      bus.B = '0;

      // Reset holds the output at zero despite live operands.
      drive(1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, "reset0");
      drive(1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, "reset1");
      drive(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "rstRelease");

      vecs.push_back('{32'h3B9A_CA07, 32'd143,       32'h0000_0000, "bigPos"});
      vecs.push_back('{32'hC465_3607, 32'd32,        32'hFFFF_FFFF, "negBEqW"});
      vecs.push_back('{32'h000F_4335, 32'd13,        32'h0000_007A, "inRangePos"});
      vecs.push_back('{32'hFFF0_BEB5, 32'd7,         32'hFFFF_E17D, "inRangeNeg"});
      vecs.push_back('{32'h8000_0000, 32'd0,         32'h8000_0000, "minB0"});
      vecs.push_back('{32'h8000_0000, 32'd31,        32'hFFFF_FFFF, "minB31"});
      vecs.push_back('{32'h7FFF_FFFF, 32'd31,        32'h0000_0000, "maxB31"});
      vecs.push_back('{32'h7FFF_FFFF, 32'd0,         32'h7FFF_FFFF, "maxB0"});
      vecs.push_back('{32'h1234_5678, 32'd4,         32'h0123_4567, "nibble"});
      vecs.push_back('{32'hF000_0000, 32'd16,        32'hFFFF_F000, "negB16"});
      vecs.push_back('{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, "negBTop"});
      vecs.push_back('{32'h0000_0001, 32'h0000_0020, 32'h0000_0000, "posB32"});
      vecs.push_back('{32'h8765_4321, 32'h0000_0021, 32'hFFFF_FFFF, "negB33Bit5"});
      vecs.push_back('{32'h8765_4321, 32'h0000_0100, 32'hFFFF_FFFF, "negBit8Only"});
      vecs.push_back('{32'hFFFF_FFF9, 32'd1,         32'hFFFF_FFFC, "floorNeg"});

      // Back-to-back: one new vector every cycle.
      foreach (vecs[i]) begin
         drive(1'b0, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].n);
      end

      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            b = $urandom_range(0, 40);
         end else begin
            b = $urandom;
         end
         drive(1'b0, a, b, sraModel(a, b), "random");
      end

      // Reset asserted mid-stream takes priority over live data.
      drive(1'b1, 32'h8000_0000, 32'd3, 32'h0000_0000, "midReset");
      drive(1'b0, 32'h8000_0000, 32'd3, 32'hF000_0000, "afterMidReset");

      waitCnt = 0;
      while (expQ.size() > 0 && waitCnt < 10) begin
         @(posedge clk);
         waitCnt++;
      end
      #2;
      nTests++;
      if (expQ.size() != 0) begin
         nFail++;
         $display("FAIL drain: %0d results still pending, required 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
